// File: rtl/ef_smsdac8_pkg.sv
// Shared types and constants for the ef_smsdac8 sample scheduler and its SPI receiver.
package ef_smsdac8_pkg;

  typedef enum logic [1:0] {
    CMD_SAMPLE = 2'b00,
    CMD_CONFIG = 2'b01,
    CMD_DIV    = 2'b10,
    CMD_CLEAR  = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SHIFT  = 2'b01,
    COMMIT = 2'b10
  } frame_state_e;

  localparam logic [7:0] MIDSCALE   = 8'h80;
  localparam int         FRAME_BITS = 16;

endpackage

// File: rtl/ef_smsdac8_spi_rx.sv
// Oversampling SPI mode-0 receiver: pin synchronisers, sclk edge detect and the
// 16-bit frame FSM. frame_vld pulses for one cycle while frame holds a full word.
module ef_smsdac8_spi_rx
  import ef_smsdac8_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_spi_sclk,
  input  logic                  i_spi_cs_b,
  input  logic                  i_spi_mosi,
  output logic                  frame_vld,
  output logic [FRAME_BITS-1:0] frame
);

  localparam int                CNT_W    = $clog2(FRAME_BITS);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(FRAME_BITS - 1);

  logic [2:0]            sclk_pipe;
  logic [2:0]            cs_pipe;
  logic [1:0]            mosi_pipe;
  logic [CNT_W-1:0]      bit_cnt;
  logic [FRAME_BITS-1:0] shift_reg;
  frame_state_e          state;
  frame_state_e          state_next;

  logic sclk_rise;
  logic cs_fall;
  logic cs_high;

  // Stage [1] is the synchronised level, stage [2] its previous value for edge detection.
  assign sclk_rise = sclk_pipe[1] & ~sclk_pipe[2];
  assign cs_fall   = ~cs_pipe[1] & cs_pipe[2];
  assign cs_high   = cs_pipe[1];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (cs_fall) state_next = SHIFT;
      end
      SHIFT: begin
        if (cs_high)                             state_next = IDLE;
        else if (sclk_rise && bit_cnt == LAST_BIT) state_next = COMMIT;
      end
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Reset clears the synchronisers too, so a chip select already low when reset
  // releases never looks like a falling edge and the partial frame is dropped.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sclk_pipe <= '0;
      cs_pipe   <= '0;
      mosi_pipe <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else begin
      sclk_pipe <= {sclk_pipe[1:0], i_spi_sclk};
      cs_pipe   <= {cs_pipe[1:0], i_spi_cs_b};
      mosi_pipe <= {mosi_pipe[0], i_spi_mosi};
      if (state == IDLE) begin
        bit_cnt <= '0;
      end else if (state == SHIFT && sclk_rise && !cs_high) begin
        shift_reg <= {shift_reg[FRAME_BITS-2:0], mosi_pipe[1]};
        bit_cnt   <= bit_cnt + CNT_W'(1);
      end
    end
  end

  assign frame_vld = (state == COMMIT);
  assign frame     = shift_reg;

endmodule

// File: rtl/ef_smsdac8_ctrl.sv
// Sample scheduler and config controller for ef_smsdac8_top: frame decode, sample
// FIFO and update-rate divider. Define SMSDAC_RAMP_EN to compile in the ramp generator.
module ef_smsdac8_ctrl
  import ef_smsdac8_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_spi_sclk,
  input  logic       i_spi_cs_b,
  input  logic       i_spi_mosi,
  output logic [7:0] o_x,
  output logic       o_en_enc,
  output logic       o_en_dith,
  output logic       o_underflow,
  output logic       o_overflow
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int PTR_W = AW + 1;

  logic                  frame_vld;
  logic [FRAME_BITS-1:0] frame;
  cmd_e                  cmd;

  logic do_sample;
  logic do_config;
  logic do_div;
  logic do_clear;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             fifo_empty;
  logic             fifo_full;

  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  logic ramp_active;
  logic pop;
  logic push_ok;
  logic underflow_set;
  logic overflow_set;
  logic frame_unused;

  ef_smsdac8_spi_rx u_spi_rx (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_spi_sclk (i_spi_sclk),
    .i_spi_cs_b (i_spi_cs_b),
    .i_spi_mosi (i_spi_mosi),
    .frame_vld  (frame_vld),
    .frame      (frame)
  );

  assign cmd       = cmd_e'(frame[15:14]);
  assign do_sample = frame_vld && (cmd == CMD_SAMPLE);
  assign do_config = frame_vld && (cmd == CMD_CONFIG);
  assign do_div    = frame_vld && (cmd == CMD_DIV);
  assign do_clear  = frame_vld && (cmd == CMD_CLEAR);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign tick       = (div_cnt == '0);

`ifdef SMSDAC_RAMP_EN
  logic ramp_sel;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ramp_sel <= 1'b0;
    end else if (do_config) begin
      ramp_sel <= frame[2];
    end
  end

  assign ramp_active  = ramp_sel;
  assign frame_unused = ^frame[13:8];
`else
  assign ramp_active  = 1'b0;
  assign frame_unused = ^{frame[13:8], frame[2]};
`endif

  // CLEAR outranks a coincident tick; a pop frees the slot a same-cycle push uses.
  assign pop           = tick && !fifo_empty && !ramp_active && !do_clear;
  assign underflow_set = tick && fifo_empty && !ramp_active && !do_clear;
  assign push_ok       = do_sample && (!fifo_full || pop);
  assign overflow_set  = do_sample && fifo_full && !pop;

  always_ff @(posedge i_clk) begin
    if (i_rst || do_clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (push_ok) begin
      mem[wr_ptr[AW-1:0]] <= frame[7:0];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || do_clear) begin
      o_x <= MIDSCALE;
    end else if (tick && ramp_active) begin
      o_x <= o_x + 8'd1;
    end else if (pop) begin
      o_x <= mem[rd_ptr[AW-1:0]];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_en_enc  <= 1'b0;
      o_en_dith <= 1'b0;
    end else if (do_config) begin
      o_en_enc  <= frame[0];
      o_en_dith <= frame[1];
    end
  end

  // A new divider value restarts the count immediately rather than waiting out the old period.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      div     <= '0;
      div_cnt <= '0;
    end else if (do_div) begin
      div     <= frame[DIV_W-1:0];
      div_cnt <= frame[DIV_W-1:0];
    end else if (tick) begin
      div_cnt <= div;
    end else begin
      div_cnt <= div_cnt - DIV_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || do_clear) begin
      o_underflow <= 1'b0;
      o_overflow  <= 1'b0;
    end else begin
      if (underflow_set) o_underflow <= 1'b1;
      if (overflow_set)  o_overflow  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ef_smsdac8_ctrl.sv
// Directed bench for ef_smsdac8_ctrl: a table of single-frame vectors followed by
// hand-written multi-frame sequences for divider pacing, overflow, reset and ramp.
module tb_ef_smsdac8_ctrl;

  typedef struct {
    logic [15:0] frame;
    logic [7:0]  x;
    logic        enc;
    logic        dith;
    logic        uf;
    logic        of;
  } vec_t;

  logic       i_clk;
  logic       i_rst;
  logic       i_spi_sclk;
  logic       i_spi_cs_b;
  logic       i_spi_mosi;
  logic [7:0] o_x;
  logic       o_en_enc;
  logic       o_en_dith;
  logic       o_underflow;
  logic       o_overflow;

  int   vecCount   = 0;
  int   miscompares = 0;
  int   used;
  vec_t vecs [9];

  ef_smsdac8_ctrl dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_spi_sclk  (i_spi_sclk),
    .i_spi_cs_b  (i_spi_cs_b),
    .i_spi_mosi  (i_spi_mosi),
    .o_x         (o_x),
    .o_en_enc    (o_en_enc),
    .o_en_dith   (o_en_dith),
    .o_underflow (o_underflow),
    .o_overflow  (o_overflow)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    vecCount++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // SCLK runs at i_clk/4; inputs change on falling i_clk edges only.
  task automatic shiftBits(input logic [15:0] f, input int first, input int count);
    for (int b = first; b < first + count; b++) begin
      if (b < 16) i_spi_mosi = f[15 - b];
      else        i_spi_mosi = 1'b1;
      i_spi_sclk = 1'b0;
      repeat (2) @(negedge i_clk);
      i_spi_sclk = 1'b1;
      repeat (2) @(negedge i_clk);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] f, input int nbits);
    i_spi_cs_b = 1'b0;
    repeat (3) @(negedge i_clk);
    shiftBits(f, 0, nbits);
    i_spi_sclk = 1'b0;
    repeat (2) @(negedge i_clk);
    i_spi_cs_b = 1'b1;
    repeat (4) @(negedge i_clk);
  endtask

  // sel 0 waits for o_x == want, sel 1 for o_underflow == want[0]; used = negedges waited.
  task automatic waitCond(input int sel, input logic [7:0] want, input int budget,
                          input string name, output int waited);
    waited = -1;
    for (int i = 0; i <= budget; i++) begin
      if ((sel == 0 && o_x == want) || (sel == 1 && o_underflow == want[0])) begin
        waited = i;
        break;
      end
      @(negedge i_clk);
    end
    vecCount++;
    if (waited < 0) begin
      miscompares++;
      $display("[TB] FAIL %s: not reached in %0d cycles, o_x=%h underflow=%b, expected %h",
               name, budget, o_x, o_underflow, want);
    end
  endtask

  initial begin
    repeat (50000) @(posedge i_clk);
    $display("[TB] FAIL watchdog: bench did not finish, vectors=%0d miscompares=%0d", vecCount, miscompares);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{16'h4003, 8'h80, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{16'h4001, 8'h80, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{16'h4002, 8'h80, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{16'h80FF, 8'h80, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{16'hC000, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{16'h0055, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{16'h8000, 8'h55, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{16'h4000, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{16'hC000, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0};

    i_rst      = 1'b1;
    i_spi_sclk = 1'b0;
    i_spi_cs_b = 1'b1;
    i_spi_mosi = 1'b0;
    repeat (3) @(negedge i_clk);
    checkOutput("reset_x", 16'(o_x), 16'h80);
    checkOutput("reset_enc", 16'(o_en_enc), 16'h0);
    checkOutput("reset_dith", 16'(o_en_dith), 16'h0);
    checkOutput("reset_uf", 16'(o_underflow), 16'h0);
    checkOutput("reset_of", 16'(o_overflow), 16'h0);
    i_rst = 1'b0;
    repeat (2) @(negedge i_clk);

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].frame, 16);
      checkOutput($sformatf("vec%0d_x", i), 16'(o_x), 16'(vecs[i].x));
      checkOutput($sformatf("vec%0d_enc", i), 16'(o_en_enc), 16'(vecs[i].enc));
      checkOutput($sformatf("vec%0d_dith", i), 16'(o_en_dith), 16'(vecs[i].dith));
      checkOutput($sformatf("vec%0d_uf", i), 16'(o_underflow), 16'(vecs[i].uf));
      checkOutput($sformatf("vec%0d_of", i), 16'(o_overflow), 16'(vecs[i].of));
    end

    // Trailing bits after the 16th are ignored; a 9-bit frame is discarded.
    applyStimulus(16'h4003, 20);
    checkOutput("extra_bits_enc", 16'(o_en_enc), 16'h1);
    checkOutput("extra_bits_dith", 16'(o_en_dith), 16'h1);
    applyStimulus(16'h4000, 9);
    checkOutput("short_frame_enc", 16'(o_en_enc), 16'h1);
    checkOutput("short_frame_dith", 16'(o_en_dith), 16'h1);

    // Re-sending DIV 255 restarts the count so no tick lands while samples queue.
    applyStimulus(16'h80FF, 16);
    applyStimulus(16'hC000, 16);
    applyStimulus(16'h0010, 16);
    applyStimulus(16'h80FF, 16);
    applyStimulus(16'h0020, 16);
    applyStimulus(16'h0030, 16);
    checkOutput("step_pre_x", 16'(o_x), 16'h80);
    checkOutput("step_pre_uf", 16'(o_underflow), 16'h0);
    applyStimulus(16'h8003, 16);
    waitCond(0, 8'h10, 40, "step_reach_10", used);
    waitCond(0, 8'h20, 40, "step_reach_20", used);
    waitCond(0, 8'h30, 40, "step_reach_30", used);
    checkOutput("step_gap_30", 16'(used), 16'd4);
    checkOutput("step_uf_before", 16'(o_underflow), 16'h0);
    waitCond(1, 8'h01, 40, "step_reach_uf", used);
    checkOutput("step_gap_uf", 16'(used), 16'd4);
    repeat (10) @(negedge i_clk);
    checkOutput("step_hold_30", 16'(o_x), 16'h30);

    applyStimulus(16'h80FF, 16);
    applyStimulus(16'h00A1, 16);
    applyStimulus(16'h00A2, 16);
    applyStimulus(16'h80FF, 16);
    applyStimulus(16'h00A3, 16);
    applyStimulus(16'h00A4, 16);
    checkOutput("ovf_full_no_flag", 16'(o_overflow), 16'h0);
    applyStimulus(16'h80FF, 16);
    applyStimulus(16'h00A5, 16);
    checkOutput("ovf_flag", 16'(o_overflow), 16'h1);
    checkOutput("ovf_x_held", 16'(o_x), 16'h30);
    applyStimulus(16'h8003, 16);
    waitCond(0, 8'hA1, 40, "ovf_reach_a1", used);
    waitCond(0, 8'hA2, 40, "ovf_reach_a2", used);
    waitCond(0, 8'hA3, 40, "ovf_reach_a3", used);
    checkOutput("ovf_gap_a3", 16'(used), 16'd4);
    waitCond(0, 8'hA4, 40, "ovf_reach_a4", used);
    checkOutput("ovf_gap_a4", 16'(used), 16'd4);
    repeat (12) @(negedge i_clk);
    checkOutput("ovf_no_fifth", 16'(o_x), 16'hA4);

    // Reset in the middle of a frame; the rest of that frame must not decode.
    i_spi_cs_b = 1'b0;
    repeat (3) @(negedge i_clk);
    shiftBits(16'h4001, 0, 8);
    i_rst = 1'b1;
    @(negedge i_clk);
    checkOutput("midrst_x", 16'(o_x), 16'h80);
    checkOutput("midrst_enc", 16'(o_en_enc), 16'h0);
    checkOutput("midrst_dith", 16'(o_en_dith), 16'h0);
    checkOutput("midrst_uf", 16'(o_underflow), 16'h0);
    checkOutput("midrst_of", 16'(o_overflow), 16'h0);
    @(negedge i_clk);
    i_rst = 1'b0;
    shiftBits(16'h4001, 8, 8);
    i_spi_sclk = 1'b0;
    repeat (2) @(negedge i_clk);
    i_spi_cs_b = 1'b1;
    repeat (4) @(negedge i_clk);
    checkOutput("midrst_discard_enc", 16'(o_en_enc), 16'h0);
    applyStimulus(16'h4002, 16);
    checkOutput("postrst_enc", 16'(o_en_enc), 16'h0);
    checkOutput("postrst_dith", 16'(o_en_dith), 16'h1);
    checkOutput("postrst_x", 16'(o_x), 16'h80);

`ifdef SMSDAC_RAMP_EN
    applyStimulus(16'h80FF, 16);
    applyStimulus(16'hC000, 16);
    applyStimulus(16'h4004, 16);
    applyStimulus(16'h8000, 16);
    waitCond(0, 8'hFE, 300, "ramp_reach_fe", used);
    @(negedge i_clk);
    checkOutput("ramp_ff", 16'(o_x), 16'hFF);
    @(negedge i_clk);
    checkOutput("ramp_00", 16'(o_x), 16'h00);
    @(negedge i_clk);
    checkOutput("ramp_01", 16'(o_x), 16'h01);
    checkOutput("ramp_no_uf", 16'(o_underflow), 16'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, miscompares);
    $finish;
  end

endmodule
